// File: rtl/pc_if.sv
// Bundle between the ID/commit stages and the fetch program counter.
// Carries o_adel only when PC_ALIGN_CHECK_EN is defined.
interface pc_if #(
  parameter int WIDTH = 32
);
  logic             i_stall;
  logic [2:0]       i_br_op;
  logic [1:0]       i_jump;
  logic [WIDTH-1:0] i_cmp_a;
  logic [WIDTH-1:0] i_cmp_b;
  logic [15:0]      i_imm16;
  logic [25:0]      i_j_addr;
  logic [WIDTH-1:0] i_jr_addr;
  logic [WIDTH-1:0] i_br_pc;
  logic             i_exc;
  logic             i_eret;
  logic [WIDTH-1:0] i_epc;
  logic [WIDTH-1:0] o_pc;
  logic [WIDTH-1:0] o_pc4;
  logic             o_taken;
  logic             o_pend;
`ifdef PC_ALIGN_CHECK_EN
  logic             o_adel;

  modport master (
    output i_stall, i_br_op, i_jump, i_cmp_a, i_cmp_b, i_imm16, i_j_addr,
           i_jr_addr, i_br_pc, i_exc, i_eret, i_epc,
    input  o_pc, o_pc4, o_taken, o_pend, o_adel
  );
  modport slave (
    input  i_stall, i_br_op, i_jump, i_cmp_a, i_cmp_b, i_imm16, i_j_addr,
           i_jr_addr, i_br_pc, i_exc, i_eret, i_epc,
    output o_pc, o_pc4, o_taken, o_pend, o_adel
  );
`else
  modport master (
    output i_stall, i_br_op, i_jump, i_cmp_a, i_cmp_b, i_imm16, i_j_addr,
           i_jr_addr, i_br_pc, i_exc, i_eret, i_epc,
    input  o_pc, o_pc4, o_taken, o_pend
  );
  modport slave (
    input  i_stall, i_br_op, i_jump, i_cmp_a, i_cmp_b, i_imm16, i_j_addr,
           i_jr_addr, i_br_pc, i_exc, i_eret, i_epc,
    output o_pc, o_pc4, o_taken, o_pend
  );
`endif
endinterface

// File: rtl/pc_unit.sv
// IF-stage program counter: branch resolution, jumps, stalls with one buffered
// redirect, exception entry and eret. Define PC_ALIGN_CHECK_EN to add o_adel.
module pc_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_PC   = 32'h0000_4180
) (
  input  logic clk,
  input  logic reset,
  pc_if.slave  ctl
);

  typedef enum logic {RUN, PEND} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] pend_target_reg, pend_target_next;
  logic             taken_reg, taken_next;

  logic [WIDTH-1:0] seq_br;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] target;
  logic             cond;
  logic             jump_req;
  logic             req;

  assign seq_br    = ctl.i_br_pc + WIDTH'(4);
  assign br_target = seq_br + {{(WIDTH-18){ctl.i_imm16[15]}}, ctl.i_imm16, 2'b00};

  generate
    if (WIDTH > 28) begin : g_j_wide
      assign j_target = {seq_br[WIDTH-1:28], ctl.i_j_addr, 2'b00};
    end else begin : g_j_narrow
      assign j_target = {ctl.i_j_addr, 2'b00};
    end
  endgenerate

  // Reserved encodings of both fields resolve to "no redirect".
  always_comb begin
    cond = 1'b0;
    case (ctl.i_br_op)
      3'b001:  cond = (ctl.i_cmp_a == ctl.i_cmp_b);
      3'b010:  cond = (ctl.i_cmp_a != ctl.i_cmp_b);
      3'b011:  cond = ($signed(ctl.i_cmp_a) <= 0);
      3'b100:  cond = ($signed(ctl.i_cmp_a) >  0);
      3'b101:  cond = ($signed(ctl.i_cmp_a) <  0);
      3'b110:  cond = ($signed(ctl.i_cmp_a) >= 0);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    jump_req = 1'b0;
    target   = br_target;
    case (ctl.i_jump)
      2'b01: begin
        jump_req = 1'b1;
        target   = j_target;
      end
      2'b10: begin
        jump_req = 1'b1;
        target   = ctl.i_jr_addr;
      end
      default: ;
    endcase
  end

  assign req = jump_req | cond;

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg + WIDTH'(4);
    pend_target_next = pend_target_reg;
    taken_next       = 1'b0;
    if (ctl.i_exc) begin
      pc_next          = EXC_PC;
      pend_target_next = '0;
      state_next       = RUN;
      taken_next       = 1'b1;
    end else if (ctl.i_eret) begin
      pc_next          = ctl.i_epc;
      pend_target_next = '0;
      state_next       = RUN;
      taken_next       = 1'b1;
    end else if (ctl.i_stall) begin
      pc_next = pc_reg;
      // Only the first redirect seen during a stall is real; later ones are wrong-path.
      if (req && state_reg == RUN) begin
        pend_target_next = target;
        state_next       = PEND;
      end
    end else if (state_reg == PEND) begin
      pc_next          = pend_target_reg;
      pend_target_next = '0;
      state_next       = RUN;
      taken_next       = 1'b1;
    end else if (req) begin
      pc_next    = target;
      taken_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      pend_target_reg <= '0;
      taken_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_target_reg <= pend_target_next;
      taken_reg       <= taken_next;
    end
  end

  assign ctl.o_pc    = pc_reg;
  assign ctl.o_pc4   = pc_reg + WIDTH'(4);
  assign ctl.o_taken = taken_reg;
  assign ctl.o_pend  = (state_reg == PEND);

`ifdef PC_ALIGN_CHECK_EN
  logic adel_reg, adel_next;

  // Flag tracks the PC being loaded, so it is valid in the same cycle as o_pc.
  always_comb begin
    adel_next = (pc_next[1:0] != 2'b00) || (pc_next < RESET_PC) ||
                (pc_next >= EXC_PC + WIDTH'(32'h0000_1000));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adel_reg <= 1'b0;
    end else begin
      adel_reg <= adel_next;
    end
  end

  assign ctl.o_adel = adel_reg;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: branches, jumps, stall buffering, exceptions,
// eret and asynchronous reset, with hand-computed expected PCs.
module tb_pc_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  pc_if #(.WIDTH(32)) bus ();

  pc_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0000_3000),
    .EXC_PC  (32'h0000_4180)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ctl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_stall = 0; bus.i_br_op = 0; bus.i_jump = 0;
    bus.i_exc = 0;   bus.i_eret = 0;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] pc,
                              input logic taken, input logic pend);
    chk({tag, "_pc"}, bus.o_pc, pc);
    chk({tag, "_taken"}, 32'(bus.o_taken), 32'(taken));
    chk({tag, "_pend"}, 32'(bus.o_pend), 32'(pend));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    idle();
    bus.i_cmp_a = 0; bus.i_cmp_b = 0; bus.i_imm16 = 0; bus.i_j_addr = 0;
    bus.i_jr_addr = 0; bus.i_br_pc = 0; bus.i_epc = 0;
    #2;
    expect_state("reset", 32'h3000, 1'b0, 1'b0);
    chk("reset_pc4", bus.o_pc4, 32'h3004);
    reset = 1'b0;

    // Free-running fetch
    tick(); expect_state("seq1", 32'h3004, 1'b0, 1'b0);
    tick(); expect_state("seq2", 32'h3008, 1'b0, 1'b0);
    tick(); expect_state("seq3", 32'h300C, 1'b0, 1'b0);
    chk("seq3_pc4", bus.o_pc4, 32'h3010);

    // beq not taken (5 vs 6), then taken to 0x3008+4-8 = 0x3004
    bus.i_br_op = 3'b001; bus.i_cmp_a = 5; bus.i_cmp_b = 6;
    bus.i_br_pc = 32'h3008; bus.i_imm16 = 16'hFFFE;
    tick(); expect_state("beq_nt", 32'h3010, 1'b0, 1'b0);
    bus.i_cmp_b = 5;
    tick(); expect_state("beq_t", 32'h3004, 1'b1, 1'b0);
    idle();
    tick(); expect_state("after_beq", 32'h3008, 1'b0, 1'b0);

    // Signed compares, target 0x3104 + 16 = 0x3114
    bus.i_br_pc = 32'h3100; bus.i_imm16 = 16'h0004;
    bus.i_br_op = 3'b101; bus.i_cmp_a = 32'h8000_0000;
    tick(); expect_state("bltz_neg", 32'h3114, 1'b1, 1'b0);
    bus.i_br_op = 3'b100; bus.i_cmp_a = 0;
    tick(); expect_state("bgtz_zero", 32'h3118, 1'b0, 1'b0);
    bus.i_br_op = 3'b011; bus.i_cmp_a = 0;
    tick(); expect_state("blez_zero", 32'h3114, 1'b1, 1'b0);
    bus.i_br_op = 3'b110; bus.i_cmp_a = 32'hFFFF_FFFF;
    tick(); expect_state("bgez_neg", 32'h3118, 1'b0, 1'b0);
    bus.i_br_op = 3'b010; bus.i_cmp_a = 1; bus.i_cmp_b = 2;
    tick(); expect_state("bne_t", 32'h3114, 1'b1, 1'b0);
    bus.i_br_op = 3'b111; bus.i_cmp_a = 7; bus.i_cmp_b = 7;
    tick(); expect_state("rsvd_br", 32'h3118, 1'b0, 1'b0);

    // Target wraps: 0xFFFFFFFC + 4 + 4 = 0x4
    bus.i_br_op = 3'b001; bus.i_cmp_a = 0; bus.i_cmp_b = 0;
    bus.i_br_pc = 32'hFFFF_FFFC; bus.i_imm16 = 16'h0001;
    tick(); expect_state("br_wrap", 32'h0000_0004, 1'b1, 1'b0);

    // j beats a true beq: {0, 0xD00, 00} = 0x3400
    bus.i_br_pc = 32'h3000; bus.i_jump = 2'b01; bus.i_j_addr = 26'h0000D00;
    tick(); expect_state("j_wins", 32'h3400, 1'b1, 1'b0);
    idle();
    bus.i_jump = 2'b11;
    tick(); expect_state("rsvd_jump", 32'h3404, 1'b0, 1'b0);

    // jr during a two-cycle stall; second req ignored; req on release dropped
    bus.i_jump = 2'b10; bus.i_jr_addr = 32'h3400; bus.i_stall = 1;
    tick(); expect_state("stall1", 32'h3404, 1'b0, 1'b1);
    bus.i_jr_addr = 32'h3800;
    tick(); expect_state("stall2", 32'h3404, 1'b0, 1'b1);
    bus.i_stall = 0;
    tick(); expect_state("unstall", 32'h3400, 1'b1, 1'b0);
    idle();
    tick(); expect_state("post_pend", 32'h3404, 1'b0, 1'b0);

    // Exception during stall with pending, then eret
    bus.i_stall = 1; bus.i_jump = 2'b10; bus.i_jr_addr = 32'h3600;
    tick(); expect_state("exc_pend", 32'h3404, 1'b0, 1'b1);
    bus.i_exc = 1;
    tick(); expect_state("exc", 32'h4180, 1'b1, 1'b0);
    idle();
    tick(); expect_state("handler", 32'h4184, 1'b0, 1'b0);
    bus.i_eret = 1; bus.i_epc = 32'h3010;
    tick(); expect_state("eret", 32'h3010, 1'b1, 1'b0);
    bus.i_exc = 1;
    tick(); expect_state("exc_eret", 32'h4180, 1'b1, 1'b0);
    bus.i_exc = 0;
    tick(); expect_state("eret2", 32'h3010, 1'b1, 1'b0);
    idle();

    // Asynchronous reset mid-pending
    bus.i_stall = 1; bus.i_jump = 2'b10; bus.i_jr_addr = 32'h3700;
    tick(); expect_state("pre_rst", 32'h3010, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1 expect_state("async_rst", 32'h3000, 1'b0, 1'b0);
    #1 reset = 1'b0;
    idle();
    tick(); expect_state("post_rst", 32'h3004, 1'b0, 1'b0);

`ifdef PC_ALIGN_CHECK_EN
    chk("adel_ok", 32'(bus.o_adel), 32'd0);
    bus.i_jump = 2'b10; bus.i_jr_addr = 32'h3002;
    tick(); chk("adel_mis", 32'(bus.o_adel), 32'd1);
    chk("adel_mis_pc", bus.o_pc, 32'h3002);
    bus.i_jr_addr = 32'h5180;
    tick(); chk("adel_range", 32'(bus.o_adel), 32'd1);
    bus.i_jr_addr = 32'h3008;
    tick(); chk("adel_clear", 32'(bus.o_adel), 32'd0);
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
